// File: rtl/risc_pkg.sv
// Shared scoreboard types: the in-flight slot record, default register count
// and the small match / range helpers used by the scoreboard and its matcher.
package risc_pkg;

  localparam int DEFAULT_NUM_REGS = 16;
  localparam int REG_AW           = $clog2(DEFAULT_NUM_REGS);

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [REG_AW-1:0] idx;
    logic              fwe;
  } sb_slot_t;

  localparam sb_slot_t SLOT_EMPTY = '{valid: 1'b0, we: 1'b0, idx: {REG_AW{1'b0}}, fwe: 1'b0};

  // A slot blocks a register read only if it will write that register; in
  // flag mode only the flag-write bit matters.
  function automatic logic slot_hit(input sb_slot_t s, input logic [REG_AW-1:0] idx,
                                    input logic match_flag);
    slot_hit = s.valid & (match_flag ? s.fwe : (s.we & (s.idx == idx)));
  endfunction

  function automatic logic idx_in_range(input logic [31:0] v, input int n);
    idx_in_range = (v < 32'(n));
  endfunction

endpackage

// File: rtl/risc_sb_match.sv
// Compares one source index (or the flags) against every slot of a slot
// array and reports whether any in-flight instruction will write it.
module risc_sb_match
  import risc_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter bit MATCH_FLAG = 1'b0
) (
  input  sb_slot_t [DEPTH-1:0] slots,
  input  logic [REG_AW-1:0]    idx,
  output logic                 hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit = hit | slot_hit(slots[i], idx, MATCH_FLAG);
    end
  end

endmodule

// File: rtl/risc_scoreboard.sv
// Fixed-latency issue scoreboard: a WB_LAT-deep shift line of in-flight
// writes drives busy/flag_busy and the OF stall. Optional SCOREBOARD_PERF_EN
// adds a saturating stall_cycles counter.
module risc_scoreboard
  import risc_pkg::*;
#(
  parameter int  NUM_REGS    = DEFAULT_NUM_REGS,
  parameter int  WB_LAT      = 3,
  parameter int  NUM_SRC     = 2,
  parameter int  FLUSH_SLOTS = 2,
  localparam int AW          = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic                    dst_we,
  input  logic [AW-1:0]           dst_idx,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [NUM_SRC*AW-1:0]   src_idx,
  input  logic                    flag_we,
  input  logic                    flag_rd,
  input  logic                    flush,
  output logic                    stall,
  output logic                    issue_fire,
  output logic [NUM_REGS-1:0]     busy,
  output logic                    flag_busy
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);

  sb_slot_t [WB_LAT-1:0] slots;
  sb_slot_t [WB_LAT-1:0] next_slots;
  sb_slot_t [WB_LAT-1:0] haz_slots;
  sb_slot_t              new_slot;
  logic [NUM_SRC-1:0]    src_hit;
  logic [NUM_SRC-1:0]    src_stall;
  logic                  flag_hit;

  always_comb begin
    if (issue_fire) begin
      new_slot = '{valid: 1'b1, we: dst_we, idx: REG_AW'(dst_idx), fwe: flag_we};
    end else begin
      new_slot = SLOT_EMPTY;
    end
  end

  // Flush kills the youngest FLUSH_SLOTS entries as they move down the line.
  always_comb begin
    next_slots    = slots;
    next_slots[0] = new_slot;
    for (int i = 1; i < WB_LAT; i++) begin
      if (flush && ((i - 1) < FLUSH_SLOTS)) begin
        next_slots[i] = SLOT_EMPTY;
      end else begin
        next_slots[i] = slots[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slots <= {WB_LAT{SLOT_EMPTY}};
    end else begin
      slots <= next_slots;
    end
  end

  always_comb begin
    busy      = {NUM_REGS{1'b0}};
    flag_busy = 1'b0;
    for (int s = 0; s < WB_LAT; s++) begin
      flag_busy = flag_busy | (slots[s].valid & slots[s].fwe);
      for (int r = 0; r < NUM_REGS; r++) begin
        busy[r] = busy[r] | (slots[s].valid & slots[s].we & (slots[s].idx == REG_AW'(r)));
      end
    end
  end

  // The oldest slot is in writeback and its result is readable this cycle,
  // so only the younger WB_LAT-1 slots can block an operand read.
  always_comb begin
    haz_slots           = slots;
    haz_slots[WB_LAT-1] = SLOT_EMPTY;
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    risc_sb_match #(.DEPTH(WB_LAT), .MATCH_FLAG(1'b0)) u_match (
      .slots (haz_slots),
      .idx   (REG_AW'(src_idx[k*AW +: AW])),
      .hit   (src_hit[k])
    );
    assign src_stall[k] = src_valid[k] & src_hit[k]
                        & idx_in_range(32'(src_idx[k*AW +: AW]), NUM_REGS);
  end

  risc_sb_match #(.DEPTH(WB_LAT), .MATCH_FLAG(1'b1)) u_flag_match (
    .slots (haz_slots),
    .idx   ({REG_AW{1'b0}}),
    .hit   (flag_hit)
  );

  always_comb begin
    if (issue_valid) begin
      stall = (|src_stall) | (flag_rd & flag_hit);
    end else begin
      stall = 1'b0;
    end
  end

  assign issue_fire = issue_valid & ~stall & ~flush;

`ifdef SCOREBOARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 32'h0000_0000;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_risc_scoreboard.sv
// Scoreboard-style bench: stimulus pushes the expected fire cycle, a monitor
// pops and compares on every issue_fire; includes a factorial run with a
// small latency-accurate register model.
module tb_risc_scoreboard;

  localparam int NR = 16;
  localparam int WL = 3;
  localparam int NS = 2;
  localparam int AW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           issue_valid, dst_we, flag_we, flag_rd, flush;
  logic [AW-1:0]  dst_idx;
  logic [NS-1:0]  src_valid;
  logic [NS*AW-1:0] src_idx;
  logic           stall, issue_fire, flag_busy;
  logic [NR-1:0]  busy;
`ifdef SCOREBOARD_PERF_EN
  logic [31:0]    stall_cycles;
`endif

  typedef struct {
    string name;
    int    cyc;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   rf_old[NR], rf_new[NR], rf_vis[NR];
  int   fl_old, fl_new, fl_vis;

  risc_scoreboard #(.NUM_REGS(NR), .WB_LAT(WL), .NUM_SRC(NS), .FLUSH_SLOTS(2)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .dst_we(dst_we),
    .dst_idx(dst_idx), .src_valid(src_valid), .src_idx(src_idx),
    .flag_we(flag_we), .flag_rd(flag_rd), .flush(flush),
    .stall(stall), .issue_fire(issue_fire), .busy(busy), .flag_busy(flag_busy)
`ifdef SCOREBOARD_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted instruction must match the oldest expectation.
  always @(negedge clk) begin
    if (issue_fire === 1'b1) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_fire: issue_fire=1 at cycle %0d, expected 0", cyc);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check({"fire_cycle_", e.name}, cyc, e.cyc);
      end
    end
  end

  task automatic idle();
    issue_valid = 1'b0; dst_we = 1'b0; dst_idx = '0; src_valid = '0; src_idx = '0;
    flag_we = 1'b0; flag_rd = 1'b0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction (called at posedge+1) and hold it until accepted.
  task automatic present(input string name, input logic we, input int d, input logic [1:0] sv,
                         input int s0, input int s1, input logic fwe, input logic frd,
                         input int stalls, output int fc);
    exp_t e;
    int   n;
    issue_valid = 1'b1; dst_we = we; dst_idx = AW'(d); src_valid = sv;
    src_idx = {AW'(s1), AW'(s0)}; flag_we = fwe; flag_rd = frd;
    e.name = name;
    e.cyc  = cyc + stalls;
    expq.push_back(e);
    n  = 0;
    fc = -1;
    forever begin
      @(negedge clk);
      if (issue_fire === 1'b1) begin
        fc = cyc;
        break;
      end
      n++;
      if (n > 12) begin
        tests++;
        fails++;
        $display("FAIL issue_timeout_%s: no issue_fire within 12 cycles", name);
        void'(expq.pop_front());
        break;
      end
    end
    step();
    idle();
  endtask

  function automatic int rd(input int r, input int c);
    return (c >= rf_vis[r]) ? rf_new[r] : rf_old[r];
  endfunction

  task automatic wr(input int r, input int v, input int c);
    rf_old[r] = rd(r, c);
    rf_new[r] = v;
    rf_vis[r] = c + WL;
  endtask

  initial begin
    int fc, pc, first, guard;
    idle();
    reset = 1'b1;
    foreach (rf_old[i]) begin rf_old[i] = 0; rf_new[i] = 0; rf_vis[i] = 0; end
    fl_old = 0; fl_new = 0; fl_vis = 0;
    repeat (2) step();
    issue_valid = 1'b1; src_valid = 2'b01;
    #1;
    check("reset_busy", busy, 32'h0);
    check("reset_flag_busy", flag_busy, 32'h0);
    check("reset_stall", stall, 32'h0);
    idle();
    step();
    reset = 1'b0;
    step();

    // Busy profile of a single producer: three cycles in flight.
    present("mov_r0_a", 1'b1, 0, 2'b00, 0, 0, 1'b0, 1'b0, 0, fc);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("busy_profile_%0d", i), busy, (i < 3) ? 32'h1 : 32'h0);
    end
    step();

    // RAW back-to-back: two stall cycles, fires on the third.
    present("mov_r0", 1'b1, 0, 2'b00, 0, 0, 1'b0, 1'b0, 0, fc);
    present("mul_r1_r1_r0", 1'b1, 1, 2'b11, 1, 0, 1'b0, 1'b0, 2, fc);
    repeat (4) step();

    // Flag producer alone, then cmp followed by dependent branch.
    present("cmp_alone", 1'b0, 0, 2'b01, 2, 0, 1'b1, 1'b0, 0, fc);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("flag_profile_%0d", i), flag_busy, (i < 3) ? 32'h1 : 32'h0);
    end
    step();
    present("cmp_r2", 1'b0, 0, 2'b01, 2, 0, 1'b1, 1'b0, 0, fc);
    present("bgt", 1'b0, 0, 2'b00, 0, 0, 1'b0, 1'b1, 2, fc);
    repeat (4) step();

    // Flush one cycle after a producer squashes it.
    present("sub_r2", 1'b1, 2, 2'b01, 2, 0, 1'b0, 1'b0, 0, fc);
    flush = 1'b1;
    @(negedge clk);
    check("busy_before_flush", busy, 32'h0004);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("busy_after_flush", busy, 32'h0);
    step();
    present("add_r3_r2", 1'b1, 3, 2'b01, 2, 0, 1'b0, 1'b0, 0, fc);

    // Flush together with a stalled issue: squash, stall still reported.
    issue_valid = 1'b1; dst_we = 1'b1; dst_idx = 4'd7; src_valid = 2'b01; src_idx = 8'h03;
    flush = 1'b1;
    @(negedge clk);
    check("flush_issue_stall", stall, 32'h1);
    check("flush_issue_fire", issue_fire, 32'h0);
    step();
    idle();
    @(negedge clk);
    check("flush_issue_no_load", busy, 32'h0);
    step();

    // Independent work, WAW, unused dst and unused sources never stall.
    present("r3_r5_r6", 1'b1, 3, 2'b11, 5, 6, 1'b0, 1'b0, 0, fc);
    present("r4_r5_r6", 1'b1, 4, 2'b11, 5, 6, 1'b0, 1'b0, 0, fc);
    present("waw_r3", 1'b1, 3, 2'b00, 0, 0, 1'b0, 1'b0, 0, fc);
    present("no_we_r4", 1'b0, 4, 2'b00, 0, 0, 1'b0, 1'b0, 0, fc);
    present("srcv0_r3", 1'b1, 8, 2'b00, 3, 3, 1'b0, 1'b0, 0, fc);
    repeat (4) step();

    // Asynchronous reset while r1/r2 are pending and a reader is stalled.
    present("w_r1", 1'b1, 1, 2'b00, 0, 0, 1'b0, 1'b0, 0, fc);
    present("w_r2", 1'b1, 2, 2'b00, 0, 0, 1'b0, 1'b0, 0, fc);
    issue_valid = 1'b1; src_valid = 2'b01; src_idx = 8'h01;
    @(negedge clk);
    check("busy_pre_reset", busy, 32'h0006);
    check("stall_pre_reset", stall, 32'h1);
    #1 reset = 1'b1;
    #1;
    check("busy_async_reset", busy, 32'h0);
    check("stall_async_reset", stall, 32'h0);
    idle();
    repeat (2) step();
    reset = 1'b0;
`ifdef SCOREBOARD_PERF_EN
    check("stall_cycles_reset", stall_cycles, 32'h0);
`endif
    step();

    // Factorial of 10 with a latency-accurate register/flag model.
    pc = 0; first = 1; guard = 0;
    while (pc < 6 && guard < 200) begin
      guard++;
      case (pc)
        0: begin present("movi_r0", 1'b1, 0, 2'b00, 0, 0, 1'b0, 1'b0, 0, fc); wr(0, 10, fc); pc = 1; end
        1: begin present("movi_r1", 1'b1, 1, 2'b00, 0, 0, 1'b0, 1'b0, 0, fc); wr(1, 1, fc); pc = 2; end
        2: begin
          present("fmul", 1'b1, 1, 2'b11, 1, 0, 1'b0, 1'b0, first ? 2 : 0, fc);
          wr(1, rd(1, fc) * rd(0, fc), fc); first = 0; pc = 3;
        end
        3: begin present("fsub", 1'b1, 0, 2'b01, 0, 0, 1'b0, 1'b0, 0, fc); wr(0, rd(0, fc) - 1, fc); pc = 4; end
        4: begin
          present("fcmp", 1'b0, 0, 2'b01, 0, 0, 1'b1, 1'b0, 2, fc);
          fl_old = (fc >= fl_vis) ? fl_new : fl_old;
          fl_new = (rd(0, fc) > 1) ? 1 : 0; fl_vis = fc + WL; pc = 5;
        end
        5: begin
          present("fbgt", 1'b0, 0, 2'b00, 0, 0, 1'b0, 1'b1, 2, fc);
          pc = (((fc >= fl_vis) ? fl_new : fl_old) != 0) ? 2 : 6;
        end
        default: pc = 6;
      endcase
    end
    repeat (4) step();
    check("fact_r1", rd(1, cyc), 32'h0037_5F00);
    check("fact_r0", rd(0, cyc), 32'h1);
`ifdef SCOREBOARD_PERF_EN
    check("stall_cycles_fact", stall_cycles, 32'd38);
`endif
    check("queue_drained", expq.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
